// File: rtl/keypad_scan_display_if.sv
// Pin bundle between the keypad/display pads and the scanner core.
// The scanner uses the master view; the board side (or a bench) uses the slave view.
interface keypad_scan_display_if #(
  parameter int SCAN_LINES  = 4,
  parameter int SENSE_LINES = 3,
  parameter int DIGITS      = 8
);
  logic [SENSE_LINES-1:0] sense_in;
  logic [SCAN_LINES-1:0]  scan_out;
  logic                   key_valid;
  logic [3:0]             key_code;
  logic [DIGITS-1:0]      light_code;
  logic [6:0]             decode;
  logic                   dp_out;

  modport master (
    input  sense_in,
    output scan_out, key_valid, key_code, light_code, decode, dp_out
  );

  modport slave (
    output sense_in,
    input  scan_out, key_valid, key_code, light_code, decode, dp_out
  );
endinterface

// File: rtl/keypad_scan_display.sv
// Matrix keypad scanner with frame-based debounce, feeding a DIGITS-deep entry
// buffer that is time-multiplexed onto a common seven-segment display.
module keypad_scan_display #(
  parameter int SCAN_LINES  = 4,
  parameter int SENSE_LINES = 3,
  parameter int DIGITS      = 8,
  parameter int SCAN_DIV    = 1000,
  parameter int MUX_DIV     = 2000,
  parameter int DEB_FRAMES  = 4,
  parameter int CLR_CODE    = 10,
  parameter int DP_CODE     = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keypad_scan_display_if.master  pins
);
  localparam int SCW = $clog2(SCAN_DIV + 1);
  localparam int SIW = (SCAN_LINES > 1) ? $clog2(SCAN_LINES) : 1;
  localparam int MCW = $clog2(MUX_DIV + 1);
  localparam int DIW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int STW = $clog2(DEB_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, PRESS_DEB, HELD, RELEASE_DEB} state_t;

  logic [SENSE_LINES-1:0] sense_meta_q, sense_sync_q;
  logic [SCW-1:0]         scan_cnt_q;
  logic [SIW-1:0]         scan_idx_q;
  logic [SCAN_LINES-1:0]  scan_q;
  logic                   slot_end, frame_end;
  logic                   line_hit;
  logic [3:0]             line_bit, line_code;
  logic                   acc_hit_q;
  logic [3:0]             acc_code_q;
  logic                   res_hit;
  logic [3:0]             res_code;

  logic                   prev_hit_q, armed_q, same_frame;
  logic [3:0]             prev_code_q;
  logic [STW-1:0]         stable_q, stable_d;
  state_t                 state_q, state_d;
  logic                   fire;
  logic                   key_valid_q;
  logic [3:0]             key_code_q;

  logic [3:0]             digit_q [DIGITS];
  logic [3:0]             digit_d [DIGITS];
  logic [DIGITS-1:0]      dp_q, dp_d;

  logic [MCW-1:0]         mux_cnt_q;
  logic [DIW-1:0]         light_idx_q, light_idx_d;
  logic [DIGITS-1:0]      light_q, light_d;
  logic                   mux_step;
  logic [6:0]             decode_q;
  logic                   dp_out_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h3F;  4'h1: seg7 = 7'h06;  4'h2: seg7 = 7'h5B;  4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;  4'h5: seg7 = 7'h6D;  4'h6: seg7 = 7'h7D;  4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;  4'h9: seg7 = 7'h6F;  4'hA: seg7 = 7'h77;  4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;  4'hD: seg7 = 7'h5E;  4'hE: seg7 = 7'h79;  default: seg7 = 7'h00;
    endcase
  endfunction

  assign slot_end  = (scan_cnt_q == SCW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (scan_idx_q == SIW'(SCAN_LINES - 1));
  assign line_hit  = |sense_sync_q;
  assign line_code = 4'(32'(scan_idx_q) * SENSE_LINES) + line_bit;

  // Lines are visited in ascending order, so the first hit in a frame is the lowest code.
  always_comb begin
    line_bit = '0;
    for (int b = SENSE_LINES - 1; b >= 0; b--) begin
      if (sense_sync_q[b]) line_bit = 4'(b);
    end
    res_hit  = acc_hit_q | line_hit;
    res_code = acc_hit_q ? acc_code_q : line_code;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sense_meta_q <= '0;
      sense_sync_q <= '0;
      scan_cnt_q   <= '0;
      scan_idx_q   <= '0;
      scan_q       <= SCAN_LINES'(1);
      acc_hit_q    <= 1'b0;
      acc_code_q   <= '0;
    end else begin
      sense_meta_q <= pins.sense_in;
      sense_sync_q <= sense_meta_q;
      if (slot_end) begin
        scan_cnt_q <= '0;
        if (frame_end) begin
          scan_idx_q <= '0;
          scan_q     <= SCAN_LINES'(1);
          acc_hit_q  <= 1'b0;
          acc_code_q <= '0;
        end else begin
          scan_idx_q <= scan_idx_q + 1'b1;
          scan_q     <= scan_q << 1;
          if (!acc_hit_q && line_hit) begin
            acc_hit_q  <= 1'b1;
            acc_code_q <= line_code;
          end
        end
      end else begin
        scan_cnt_q <= scan_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    same_frame = (res_hit == prev_hit_q) && (!res_hit || (res_code == prev_code_q));
    if (!same_frame)                        stable_d = STW'(1);
    else if (stable_q >= STW'(DEB_FRAMES))  stable_d = stable_q;
    else                                    stable_d = stable_q + 1'b1;

    state_d = state_q;
    fire    = 1'b0;
    if (frame_end) begin
      case (state_q)
        IDLE:        if (res_hit && armed_q) state_d = PRESS_DEB;
        PRESS_DEB: begin
          if (!res_hit || !same_frame) state_d = IDLE;
          else if (stable_d >= STW'(DEB_FRAMES)) begin
            state_d = HELD;
            fire    = 1'b1;
          end
        end
        HELD:        if (!res_hit) state_d = RELEASE_DEB;
        RELEASE_DEB: begin
          if (res_hit) state_d = HELD;
          else if (stable_d >= STW'(DEB_FRAMES)) state_d = IDLE;
        end
        default:     state_d = IDLE;
      endcase
    end
  end

  // armed_q blocks a key held through reset until an empty frame has been seen.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_hit_q  <= 1'b0;
      prev_code_q <= '0;
      stable_q    <= '0;
      armed_q     <= 1'b0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= fire;
      if (fire) key_code_q <= res_code;
      if (frame_end) begin
        prev_hit_q  <= res_hit;
        prev_code_q <= res_code;
        stable_q    <= stable_d;
        if (!res_hit) armed_q <= 1'b1;
      end
    end
  end

  always_comb begin
    digit_d = digit_q;
    dp_d    = dp_q;
    if (fire) begin
      if (res_code <= 4'd9) begin
        for (int i = DIGITS - 1; i > 0; i--) begin
          digit_d[i] = digit_q[i-1];
          dp_d[i]    = dp_q[i-1];
        end
        digit_d[0] = res_code;
        dp_d[0]    = 1'b0;
      end else if (res_code == 4'(CLR_CODE)) begin
        for (int i = 0; i < DIGITS; i++) digit_d[i] = 4'hF;
        dp_d = '0;
      end else if (res_code == 4'(DP_CODE)) begin
        dp_d[0] = ~dp_q[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) digit_q[i] <= 4'hF;
      dp_q <= '0;
    end else begin
      digit_q <= digit_d;
      dp_q    <= dp_d;
    end
  end

  always_comb begin
    mux_step    = (mux_cnt_q == MCW'(MUX_DIV - 1));
    light_idx_d = light_idx_q;
    light_d     = light_q;
    if (mux_step) begin
      light_idx_d = (light_idx_q == DIW'(DIGITS - 1)) ? '0 : light_idx_q + 1'b1;
      light_d     = (light_q << 1) | (light_q >> (DIGITS - 1));
    end
  end

  // Segments are refreshed every cycle from the digit about to be lit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mux_cnt_q   <= '0;
      light_idx_q <= '0;
      light_q     <= DIGITS'(1);
      decode_q    <= '0;
      dp_out_q    <= 1'b0;
    end else begin
      mux_cnt_q   <= mux_step ? '0 : mux_cnt_q + 1'b1;
      light_idx_q <= light_idx_d;
      light_q     <= light_d;
      decode_q    <= seg7(digit_q[light_idx_d]);
      dp_out_q    <= dp_q[light_idx_d];
    end
  end

  assign pins.scan_out   = scan_q;
  assign pins.key_valid  = key_valid_q;
  assign pins.key_code   = key_code_q;
  assign pins.light_code = light_q;
  assign pins.decode     = decode_q;
  assign pins.dp_out     = dp_out_q;
endmodule

// File: doc/keypad_scan_display.md
Name: keypad_scan_display

Overview:
- Parametrised successor to the team's fixed 4x3 keypad / seven-segment combo.
- Scans a SCAN_LINES x SENSE_LINES matrix keypad, debounces each key, and emits one event per press.
- Keeps the last DIGITS entered values in a shift buffer and time-multiplexes them onto a common seven-segment display with a per-digit decimal point.
- Sits between the board keypad pins and the display pins.

Parameters:
- SCAN_LINES, 4: driven keypad lines.
- SENSE_LINES, 3: sensed keypad lines. SCAN_LINES*SENSE_LINES must be ≤16.
- DIGITS, 8: display digits and buffer depth.
- SCAN_DIV, 1000: clk cycles each scan line is driven.
- MUX_DIV, 2000: clk cycles each display digit is lit.
- DEB_FRAMES, 4: consecutive identical scan frames needed to accept a press or a release.
- CLR_CODE, 10: key code that clears the buffer.
- DP_CODE, 11: key code that toggles the DP of digit 0.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- sense_in  in  SENSE_LINES  keypad sense pins. Asynchronous; high = key closed on the currently driven line.
- scan_out  out  SCAN_LINES  one-hot drive, active-high
- key_valid  out  1  one-cycle pulse per accepted press
- key_code  out  4  code of the last accepted key; held between pulses
- light_code  out  DIGITS  one-hot digit enable, active-high
- decode  out  7  segments {g,f,e,d,c,b,a}, active-high
- dp_out  out  1  decimal point for the lit digit, active-high

Behaviour:
- One clock domain; rst_n is synchronous and active-low.
- Reset values:
  - scan_out = 1 (line 0), light_code = 1 (digit 0).
  - key_valid = 0, key_code = 0.
  - All buffer entries = 4'hF (blank); all DP bits = 0.
  - decode = 0, dp_out = 0.
  - FSM in IDLE; all counters cleared.
- Reset mid-scan or mid-debounce discards all partial state. No event is emitted for a key held through reset until that key has been released and pressed again.
- sense_in passes through a 2-flop synchroniser (2-cycle latency).
- Scan:
  - A SCAN_DIV counter advances the scan index 0..SCAN_LINES-1, wrapping to 0.
  - On the last cycle of each slot, the synchronised sense value is sampled for that line.
  - A frame is one full pass over all lines. At frame end it yields pressed (any bit set) and code = line*SENSE_LINES + sense_bit.
  - If several keys are closed, the lowest code wins.
- Debounce FSM, evaluated at each frame end. The stable counter resets whenever the frame result differs from the previous frame.
  - IDLE: pressed → PRESS_DEB.
  - PRESS_DEB: same code for DEB_FRAMES frames → HELD, and key_valid=1 for exactly one cycle with key_code=code. A code change or release → IDLE.
  - HELD: not pressed → RELEASE_DEB. There is no auto-repeat; a different key appearing while held is ignored.
  - RELEASE_DEB: not pressed for DEB_FRAMES frames → IDLE. Any press → HELD.
- Buffer action, in the same cycle as the key_valid pulse:
  - code ≤ 9: shift. digit[i] ← digit[i-1], digit[0] ← code. DP bits shift with their digits and digit[0].dp ← 0. digit[DIGITS-1] is discarded.
  - code == CLR_CODE: all digits ← F, all DP ← 0.
  - code == DP_CODE: digit[0].dp toggles.
  - Any other code: key_valid still pulses; the buffer is unchanged.
- Display mux:
  - A MUX_DIV counter rotates light_code one-hot (bit DIGITS-1 wraps to bit 0). It is independent of the scan.
  - decode and dp_out are registered from the selected entry and change in the same cycle as light_code.
  - Segment table 0–9 (gfedcba): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. A–E, the hex glyphs for values 10–14, are never written to the buffer. Value F = 00 (blank).
  - A buffer write takes effect on the next mux refresh of the affected digit, no later than the next mux step.

Test Plan (SCAN_DIV=4, MUX_DIV=8, DEB_FRAMES=2, 4x3, DIGITS=4):
- Reset, then hold rst_n=0 for 3 cycles → scan_out=0001, light_code=0001, decode=00, dp_out=0. Release → scan_out steps 0001→0010 every 4 cycles and wraps 1000→0001.
- Close key line1/sense2 (code 5) for 3 frames → exactly one key_valid with key_code=5. When digit 0 is lit, decode=6D and dp_out=0. No second pulse while held.
- Enter 1,2,3,4,7 with clean releases between → buffer digit3..0 = 2,3,4,7. light_code=1000 shows decode=5B; the 1 has been discarded.
- Bounce code 3 for 1 frame, open, then bounce again → no key_valid. A key held exactly 2 stable frames → one pulse.
- Press 5, then DP_CODE 11, then 11 again → dp_out=1 on digit 0 after the first 11, back to 0 after the second. key_valid pulses three times.
- Hold codes 4 and 8 together → key_code=4. Press CLR_CODE 10 → all decode=00 and dp_out=0 on every digit. Assert rst_n=0 mid-PRESS_DEB → no pulse after reset until release and re-press.
